// File: rtl/parking_controller.sv
// rtl/parking_controller.sv - entry/exit arbitration, slot allocation, tokens, timestamps and gate sequencing for an 8-slot lot
//
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   tick_en          : time-unit strobe, advances the free-running tick counter
//   entry_req        : car waiting at entry (level, held until served)
//   exit_req         : car waiting at exit (level, held until served)
//   exit_token[2:0]  : token presented at exit
//   pattern[2:0]     : token scrambling key
//   entry_ack        : one-cycle pulse, entry accepted
//   token[2:0]       : slot ^ pattern of the last admitted car
//   exit_ack         : one-cycle pulse, exit accepted
//   exit_nack        : one-cycle pulse, presented token maps to an empty slot
//   time_total[7:0]  : parking duration in ticks of the last accepted exit
//   gate_open        : barrier open
//   occupancy[7:0]   : bit i = slot i occupied
//   parked[3:0]      : number of occupied slots
//   empty[3:0]       : number of free slots
//   full             : all slots occupied
module parking_controller #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_token,
  input  logic [2:0] pattern,
  output logic       entry_ack,
  output logic [2:0] token,
  output logic       exit_ack,
  output logic       exit_nack,
  output logic [7:0] time_total,
  output logic       gate_open,
  output logic [7:0] occupancy,
  output logic [3:0] parked,
  output logic [3:0] empty,
  output logic       full
);

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_RELEASE} state_t;

  state_t     state_q, state_d;
  logic [7:0] occ_q, occ_d;
  logic [7:0] stamp_q [8];
  logic [7:0] stamp_d [8];
  logic [7:0] tick_q, tick_d;
  logic       prio_q, prio_d;              // 0: exit favoured, 1: entry favoured
  logic       served_entry_q, served_entry_d;
  logic [7:0] gate_cnt_q, gate_cnt_d;
  logic [2:0] token_q, token_d;
  logic [7:0] time_total_q, time_total_d;
  logic       entry_ack_q, entry_ack_d;
  logic       exit_ack_q, exit_ack_d;
  logic       exit_nack_q, exit_nack_d;

  logic [2:0] free_slot;
  logic [2:0] exit_slot;
  logic [3:0] parked_c;
  logic       full_c;
  logic       entry_elig;
  logic       serve_entry;
  logic       serve_exit;

  // Lowest free slot: scanning downward lets the lowest zero win.
  always_comb begin
    free_slot = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!occ_q[i]) free_slot = 3'(i);
    end
  end

  always_comb begin
    parked_c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      parked_c = parked_c + {3'd0, occ_q[i]};
    end
  end

  assign full_c     = &occ_q;
  assign exit_slot  = exit_token ^ pattern;
  assign entry_elig = entry_req & ~full_c;

  always_comb begin
    serve_entry = 1'b0;
    serve_exit  = 1'b0;
    if (entry_elig && exit_req) begin
      if (prio_q) serve_entry = 1'b1;
      else        serve_exit  = 1'b1;
    end else if (entry_elig) begin
      serve_entry = 1'b1;
    end else if (exit_req) begin
      serve_exit = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    occ_d          = occ_q;
    stamp_d        = stamp_q;
    tick_d         = tick_q + {7'd0, tick_en};
    prio_d         = prio_q;
    served_entry_d = served_entry_q;
    gate_cnt_d     = gate_cnt_q;
    token_d        = token_q;
    time_total_d   = time_total_q;
    entry_ack_d    = 1'b0;
    exit_ack_d     = 1'b0;
    exit_nack_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (serve_entry) begin
          occ_d[free_slot]   = 1'b1;
          stamp_d[free_slot] = tick_q;
          token_d            = free_slot ^ pattern;
          entry_ack_d        = 1'b1;
          gate_cnt_d         = 8'(GATE_CYCLES);
          served_entry_d     = 1'b1;
          state_d            = S_GATE;
          // Both sides were eligible only if exit_req is high: hand priority over.
          if (exit_req) prio_d = 1'b0;
        end else if (serve_exit) begin
          served_entry_d = 1'b0;
          if (entry_elig) prio_d = 1'b1;
          if (occ_q[exit_slot]) begin
            occ_d[exit_slot] = 1'b0;
            time_total_d     = tick_q - stamp_q[exit_slot];
            exit_ack_d       = 1'b1;
            gate_cnt_d       = 8'(GATE_CYCLES);
            state_d          = S_GATE;
          end else begin
            exit_nack_d = 1'b1;
            state_d     = S_RELEASE;
          end
        end
      end
      S_GATE: begin
        gate_cnt_d = gate_cnt_q - 8'd1;
        if (gate_cnt_q == 8'd1) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold here until the served requester lets go, so a level request
        // is never served twice.
        if (served_entry_q ? !entry_req : !exit_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      occ_q          <= 8'd0;
      for (int i = 0; i < 8; i++) stamp_q[i] <= 8'd0;
      tick_q         <= 8'd0;
      prio_q         <= 1'b0;
      served_entry_q <= 1'b0;
      gate_cnt_q     <= 8'd0;
      token_q        <= 3'd0;
      time_total_q   <= 8'd0;
      entry_ack_q    <= 1'b0;
      exit_ack_q     <= 1'b0;
      exit_nack_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      occ_q          <= occ_d;
      for (int i = 0; i < 8; i++) stamp_q[i] <= stamp_d[i];
      tick_q         <= tick_d;
      prio_q         <= prio_d;
      served_entry_q <= served_entry_d;
      gate_cnt_q     <= gate_cnt_d;
      token_q        <= token_d;
      time_total_q   <= time_total_d;
      entry_ack_q    <= entry_ack_d;
      exit_ack_q     <= exit_ack_d;
      exit_nack_q    <= exit_nack_d;
    end
  end

  assign entry_ack  = entry_ack_q;
  assign token      = token_q;
  assign exit_ack   = exit_ack_q;
  assign exit_nack  = exit_nack_q;
  assign time_total = time_total_q;
  assign gate_open  = (state_q == S_GATE);
  assign occupancy  = occ_q;
  assign parked     = parked_c;
  assign empty      = 4'd8 - parked_c;
  assign full       = full_c;

endmodule

// File: tb/tb_parking_controller.sv
// tb/tb_parking_controller.sv - randomized self-checking bench for parking_controller against a slot/stamp model
module tb_parking_controller;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_token;
  logic [2:0] pattern;
  logic       entry_ack;
  logic [2:0] token;
  logic       exit_ack;
  logic       exit_nack;
  logic [7:0] time_total;
  logic       gate_open;
  logic [7:0] occupancy;
  logic [3:0] parked;
  logic [3:0] empty;
  logic       full;

  parking_controller #(.GATE_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
    .entry_req(entry_req), .exit_req(exit_req),
    .exit_token(exit_token), .pattern(pattern),
    .entry_ack(entry_ack), .token(token),
    .exit_ack(exit_ack), .exit_nack(exit_nack),
    .time_total(time_total), .gate_open(gate_open),
    .occupancy(occupancy), .parked(parked), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_rand = 0;

  // Reference model: which slots hold a car, and the time each arrived.
  bit         park [8];
  logic [7:0] mstamp [8];
  logic [7:0] m_tick;   // elapsed time units
  logic [7:0] t_edge;   // time value seen by the most recent clock edge

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tick <= 8'd0;
      t_edge <= 8'd0;
    end else begin
      t_edge <= m_tick;
      if (tick_en) m_tick <= m_tick + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    tick_en = (tick_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!park[i]) return i;
    return 0;
  endfunction

  function automatic int count_parked();
    int c = 0;
    for (int i = 0; i < 8; i++) if (park[i]) c++;
    return c;
  endfunction

  task automatic chk_occ();
    logic [7:0] o;
    int c;
    o = 8'd0;
    c = 0;
    for (int i = 0; i < 8; i++) if (park[i]) begin o[i] = 1'b1; c++; end
    chk("occupancy", occupancy, o);
    chk("parked", parked, c);
    chk("empty", empty, 8 - c);
    chk("full", full, (c == 8) ? 1 : 0);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin step(); lat++; end while (!(entry_ack || exit_ack || exit_nack) && lat < 40);
  endtask

  task automatic on_entry_ack();
    int s;
    logic [2:0] exp_tok;
    s = lowest_free();
    exp_tok = 3'(s) ^ pattern;
    chk("token", token, exp_tok);
    park[s] = 1'b1;
    mstamp[s] = t_edge;
    chk_occ();
  endtask

  task automatic on_exit_ack(input int s);
    logic [7:0] exp_t;
    exp_t = t_edge - mstamp[s];
    chk("time_total", time_total, exp_t);
    park[s] = 1'b0;
    chk_occ();
  endtask

  // Called at the negedge on which an ack is visible; ends with the DUT idle.
  task automatic tail();
    int g;
    g = 1;
    step();
    chk("ack_pulse", entry_ack | exit_ack, 0);
    while (gate_open && g < 300) begin g++; step(); end
    chk("gate_len", g, G);
    step();
  endtask

  task automatic do_entry();
    int lat;
    entry_req = 1'b1;
    wait_resp(lat);
    chk("entry_lat", lat, 1);
    chk("entry_ack", entry_ack, 1);
    chk("gate_on_ack", gate_open, 1);
    on_entry_ack();
    entry_req = 1'b0;
    tail();
  endtask

  task automatic do_exit(input int s, input int hold);
    int lat;
    exit_token = 3'(s) ^ pattern;
    exit_req = 1'b1;
    wait_resp(lat);
    chk("exit_lat", lat, 1);
    if (park[s]) begin
      chk("exit_ack", exit_ack, 1);
      chk("exit_nack_on_ack", exit_nack, 0);
      on_exit_ack(s);
      exit_req = 1'b0;
      tail();
    end else begin
      chk("exit_nack", exit_nack, 1);
      chk("nack_no_ack", exit_ack, 0);
      chk("nack_gate", gate_open, 0);
      chk_occ();
      for (int i = 0; i < hold; i++) begin
        step();
        chk("nack_repeat", exit_nack, 0);
        chk("nack_gate_hold", gate_open, 0);
      end
      exit_req = 1'b0;
      step();
    end
  endtask

  task automatic do_reset(input logic [2:0] new_pat);
    rst_n = 1'b0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    for (int i = 0; i < 8; i++) begin park[i] = 1'b0; mstamp[i] = 8'd0; end
    step();
    step();
    pattern = new_pat;
    rst_n = 1'b1;
    step();
    chk("rst_token", token, 0);
    chk("rst_time_total", time_total, 0);
    chk_occ();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    bit exp_entry;
    rst_n = 1'b0;
    tick_en = 1'b0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    exit_token = 3'd0;
    pattern = 3'b101;
    for (int i = 0; i < 8; i++) begin park[i] = 1'b0; mstamp[i] = 8'd0; end
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_entry_ack", entry_ack, 0);
    chk("rst_exit_ack", exit_ack, 0);
    chk("rst_exit_nack", exit_nack, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_token", token, 0);
    chk("rst_time_total", time_total, 0);
    chk_occ();
    rst_n = 1'b1;
    step();

    // Admit from reset, then a 10-tick stay
    do_entry();
    chk("admit_token", token, 3'b101);
    chk("admit_occ", occupancy, 8'h01);
    for (int i = 0; i < 10; i++) begin tick_en = 1'b1; step(); end
    do_exit(0, 0);
    chk("duration", time_total, 10);
    chk("duration_occ", occupancy, 8'h00);

    // Fill the lot, hold a 9th entry, free slot 3
    for (int i = 0; i < 8; i++) do_entry();
    chk("lot_full", full, 1);
    entry_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (entry_ack) seen++; end
    chk("full_no_ack", seen, 0);
    do_exit(3, 0);
    do_entry();
    chk("refill_token", token, 3'd3 ^ pattern);
    chk("refill_full", full, 1);

    // Invalid token with a held request
    do_reset(3'b101);
    do_entry();
    do_exit(2, 3);
    chk("nack_occ", occupancy, 8'h01);

    // Simultaneous requests: exit first, entry after release
    exit_token = 3'd0 ^ pattern;
    entry_req = 1'b1;
    exit_req = 1'b1;
    wait_resp(lat);
    chk("arb_exit_first", exit_ack, 1);
    chk("arb_entry_held", entry_ack, 0);
    on_exit_ack(0);
    exit_req = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!entry_ack && lat < 40);
    chk("arb_entry_after", entry_ack, 1);
    chk("arb_spacing", lat, G + 2);
    on_entry_ack();
    entry_req = 1'b0;
    tail();

    // Both re-requesting continuously: services alternate, entry first now
    exit_token = 3'd0 ^ pattern;
    entry_req = 1'b1;
    exit_req = 1'b1;
    exp_entry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_resp(lat);
      chk("alt_lat", lat, 1);
      if (exp_entry) begin
        chk("alt_entry", entry_ack, 1);
        chk("alt_entry_only", exit_ack, 0);
        on_entry_ack();
        entry_req = 1'b0;
        tail();
        entry_req = 1'b1;
      end else begin
        chk("alt_exit", exit_ack, 1);
        chk("alt_exit_only", entry_ack, 0);
        on_exit_ack(0);
        exit_req = 1'b0;
        tail();
        exit_req = 1'b1;
      end
      exp_entry = !exp_entry;
    end
    entry_req = 1'b0;
    exit_req = 1'b0;
    step();

    // Tick wrap: stamped at 250, leaving at 4
    do_reset(3'b011);
    while (m_tick != 8'd250) begin tick_en = 1'b1; step(); end
    do_entry();
    while (m_tick != 8'd4) begin tick_en = 1'b1; step(); end
    do_exit(0, 0);
    chk("wrap_total", time_total, 10);

    // Randomized traffic against the model
    do_reset(3'($urandom_range(0, 7)));
    tick_rand = 1;
    for (int n = 0; n < 120; n++) begin
      int op;
      int c;
      int s;
      op = $urandom_range(0, 3);
      c = count_parked();
      if (op < 2 && c < 8) begin
        do_entry();
      end else if (op == 2 && c > 0) begin
        do begin s = $urandom_range(0, 7); end while (!park[s]);
        do_exit(s, 0);
      end else begin
        do_exit($urandom_range(0, 7), $urandom_range(0, 2));
      end
      repeat ($urandom_range(0, 3)) step();
    end
    tick_rand = 0;

    // Reset asserted while the gate is open
    entry_req = 1'b1;
    wait_resp(lat);
    entry_req = 1'b0;
    step();
    chk("pre_reset_gate", gate_open, 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) park[i] = 1'b0;
    chk("reset_gate", gate_open, 0);
    chk_occ();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_reset_gate", gate_open, 0);
    chk("post_reset_ack", entry_ack, 0);
    chk_occ();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
